// File: rtl/sized_level_fifo_pkg.sv
// Shared types for the sized level FIFO: the per-cycle operation after
// enqueue/dequeue acceptance has been resolved.
package sized_level_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic enq_ok, input logic deq_ok);
        return fifo_op_e'({enq_ok, deq_ok});
    endfunction

endpackage

// File: rtl/sized_fifo_ring.sv
// Ring storage for the sized level FIFO: one synchronous write port plus the
// registered head read that forms D_OUT (loaded from the ring or from D_IN).
module sized_fifo_ring #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 2,
    parameter int AW      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wr_ptr,
    input  logic [AW-1:0]    rd_ptr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             out_ld,
    input  logic             out_from_ring,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [WIDTH-1:0] dout_q, dout_d;

    // Contents are deliberately not reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        dout_d = out_from_ring ? mem[rd_ptr] : wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (out_ld) dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/sized_level_fifo.sv
// FIFO with an output register, occupancy count, registered almost-full /
// almost-empty flags and sticky overflow/underflow flags.
module sized_level_fifo
    import sized_level_fifo_pkg::*;
#(
    parameter int p1width       = 1,
    parameter int p2depth       = 3,
    parameter int p3cntr_width  = 1,
    parameter int p4count_width = 2,
    parameter int p5af_level    = 2,
    parameter int p6ae_level    = 1,
    parameter int guarded       = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CLR,
    input  logic [p1width-1:0]       D_IN,
    input  logic                     ENQ,
    input  logic                     DEQ,
    output logic [p1width-1:0]       D_OUT,
    output logic                     EMPTY_N,
    output logic                     FULL_N,
    output logic [p4count_width-1:0] COUNT,
    output logic                     ALMOST_FULL_N,
    output logic                     ALMOST_EMPTY_N,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int RING = p2depth - 1;
    localparam int LAST = p2depth - 2;
    localparam logic [p3cntr_width-1:0]  PTR_LAST = p3cntr_width'(LAST);
    localparam logic [p3cntr_width-1:0]  PTR_ONE  = p3cntr_width'(1);
    localparam logic [p4count_width-1:0] CNT_FULL = p4count_width'(p2depth);
    localparam logic [p4count_width-1:0] CNT_TWO  = p4count_width'(2);
    localparam logic [p4count_width-1:0] AF_LVL   = p4count_width'(p5af_level);
    localparam logic [p4count_width-1:0] AE_LVL   = p4count_width'(p6ae_level);

    logic [p3cntr_width-1:0]  head_q, head_d, tail_q, tail_d;
    logic [p4count_width-1:0] count_q, count_d;
    logic empty_n_q, empty_n_d, full_n_q, full_n_d;
    logic af_n_q, af_n_d, ae_n_q, ae_n_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic enq_ok, deq_ok, ring_empty;
    logic ring_we, out_ld, out_from_ring;

    function automatic logic [p3cntr_width-1:0] ptr_inc(input logic [p3cntr_width-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // The ring only holds data once the output register is occupied.
    assign ring_empty = (count_q < CNT_TWO);

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        ring_we       = 1'b0;
        out_ld        = 1'b0;
        out_from_ring = 1'b0;
        enq_ok        = ENQ && (full_n_q || (DEQ && empty_n_q && (guarded == 0)));
        deq_ok        = DEQ && empty_n_q;

        if (CLR) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (ENQ && !enq_ok) ovf_d = 1'b1;
            if (DEQ && !empty_n_q) unf_d = 1'b1;
            case (fifo_op(enq_ok, deq_ok))
                OP_ENQ: begin
                    if (!empty_n_q) begin
                        out_ld = 1'b1;
                    end else begin
                        ring_we = 1'b1;
                        tail_d  = ptr_inc(tail_q);
                    end
                end
                OP_DEQ: begin
                    if (!ring_empty) begin
                        out_ld        = 1'b1;
                        out_from_ring = 1'b1;
                        head_d        = ptr_inc(head_q);
                    end
                end
                OP_BOTH: begin
                    out_ld = 1'b1;
                    if (!ring_empty) begin
                        // When full, head==tail: the read sees the old entry.
                        ring_we       = 1'b1;
                        out_from_ring = 1'b1;
                        tail_d        = ptr_inc(tail_q);
                        head_d        = ptr_inc(head_q);
                    end
                end
                default: ;
            endcase
            count_d = count_q + p4count_width'(enq_ok) - p4count_width'(deq_ok);
        end

        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_FULL);
        af_n_d    = !(count_d >= AF_LVL);
        ae_n_d    = !(count_d <= AE_LVL);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            af_n_q    <= 1'b1;
            ae_n_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            af_n_q    <= af_n_d;
            ae_n_q    <= ae_n_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    sized_fifo_ring #(
        .WIDTH   (p1width),
        .ENTRIES (RING),
        .AW      (p3cntr_width)
    ) u_ring (
        .clk           (CLK),
        .rst_n         (RST_N),
        .we            (ring_we),
        .wr_ptr        (tail_q),
        .rd_ptr        (head_q),
        .wr_data       (D_IN),
        .out_ld        (out_ld),
        .out_from_ring (out_from_ring),
        .dout          (D_OUT)
    );

    assign EMPTY_N        = empty_n_q;
    assign FULL_N         = full_n_q;
    assign COUNT          = count_q;
    assign ALMOST_FULL_N  = af_n_q;
    assign ALMOST_EMPTY_N = ae_n_q;
    assign OVF            = ovf_q;
    assign UNF            = unf_q;

endmodule

// File: tb/tb_sized_level_fifo.sv
// Bench for sized_level_fifo: an unguarded and a guarded instance share the
// stimulus; an ordered-list model per instance is compared every cycle.
module tb_sized_level_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0, enq = 1'b0, deq = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout [2];
    logic [2:0] count [2];
    logic       empty_n [2], full_n [2], af_n [2], ae_n [2], ovf [2], unf [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sized_level_fifo #(
        .p1width(8), .p2depth(4), .p3cntr_width(2), .p4count_width(3),
        .p5af_level(3), .p6ae_level(1), .guarded(0)
    ) u0 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .D_IN(din), .ENQ(enq), .DEQ(deq),
        .D_OUT(dout[0]), .EMPTY_N(empty_n[0]), .FULL_N(full_n[0]), .COUNT(count[0]),
        .ALMOST_FULL_N(af_n[0]), .ALMOST_EMPTY_N(ae_n[0]), .OVF(ovf[0]), .UNF(unf[0])
    );

    sized_level_fifo #(
        .p1width(8), .p2depth(4), .p3cntr_width(2), .p4count_width(3),
        .p5af_level(3), .p6ae_level(1), .guarded(1)
    ) u1 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .D_IN(din), .ENQ(enq), .DEQ(deq),
        .D_OUT(dout[1]), .EMPTY_N(empty_n[1]), .FULL_N(full_n[1]), .COUNT(count[1]),
        .ALMOST_FULL_N(af_n[1]), .ALMOST_EMPTY_N(ae_n[1]), .OVF(ovf[1]), .UNF(unf[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: list[0] is the head; index 1 (g==1) is the guarded instance.
    logic [7:0] mq [2][8];
    int         mn [2] = '{0, 0};
    bit         mo [2] = '{0, 0};
    bit         mu [2] = '{0, 0};
    bit         m_eok, m_dok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                mn[g] = 0; mo[g] = 0; mu[g] = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (clr) begin
                    mn[g] = 0; mo[g] = 0; mu[g] = 0;
                end else begin
                    m_dok = deq && (mn[g] > 0);
                    m_eok = enq && ((mn[g] < 4) || (m_dok && g == 0));
                    if (deq && mn[g] == 0) mu[g] = 1;
                    if (enq && !m_eok) mo[g] = 1;
                    if (m_dok) begin
                        for (int i = 0; i < 7; i++) mq[g][i] = mq[g][i+1];
                        mn[g]--;
                    end
                    if (m_eok) begin
                        mq[g][mn[g]] = din;
                        mn[g]++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d_empty_n", g), 32'(empty_n[g]), 32'(mn[g] != 0));
            chk($sformatf("g%0d_full_n", g),  32'(full_n[g]),  32'(mn[g] != 4));
            chk($sformatf("g%0d_count", g),   32'(count[g]),   32'(mn[g]));
            chk($sformatf("g%0d_af_n", g),    32'(af_n[g]),    32'(mn[g] < 3));
            chk($sformatf("g%0d_ae_n", g),    32'(ae_n[g]),    32'(mn[g] > 1));
            chk($sformatf("g%0d_ovf", g),     32'(ovf[g]),     32'(mo[g]));
            chk($sformatf("g%0d_unf", g),     32'(unf[g]),     32'(mu[g]));
            if (mn[g] > 0) chk($sformatf("g%0d_dout", g), 32'(dout[g]), 32'(mq[g][0]));
        end
    end

    task automatic step(input logic e, input logic d, input logic [7:0] v, input logic c);
        enq = e; deq = d; din = v; clr = c;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"},    32'(dout[0]),    32'h0);
        chk({tag, "_empty_n"}, 32'(empty_n[0]), 32'h0);
        chk({tag, "_full_n"},  32'(full_n[0]),  32'h1);
        chk({tag, "_count"},   32'(count[0]),   32'h0);
        chk({tag, "_af_n"},    32'(af_n[0]),    32'h1);
        chk({tag, "_ae_n"},    32'(ae_n[0]),    32'h0);
        chk({tag, "_ovf"},     32'(ovf[0]),     32'h0);
        chk({tag, "_unf"},     32'(unf[0]),     32'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Fill to full, watching the level flags.
        step(1, 0, 8'h11, 0); chk("fill1_count", 32'(count[0]), 1); chk("fill1_ae_n", 32'(ae_n[0]), 0);
        step(1, 0, 8'h22, 0); chk("fill2_ae_n", 32'(ae_n[0]), 1); chk("fill2_af_n", 32'(af_n[0]), 1);
        step(1, 0, 8'h33, 0); chk("fill3_af_n", 32'(af_n[0]), 0);
        step(1, 0, 8'h44, 0); chk("fill4_full_n", 32'(full_n[0]), 0);
        chk("fill4_count", 32'(count[0]), 4); chk("fill4_dout", 32'(dout[0]), 32'h11);

        step(0, 1, 8'h00, 0); chk("drain1_dout", 32'(dout[0]), 32'h22);
        step(0, 1, 8'h00, 0); chk("drain2_dout", 32'(dout[0]), 32'h33);
        step(0, 1, 8'h00, 0); chk("drain3_dout", 32'(dout[0]), 32'h44);
        step(0, 1, 8'h00, 0); chk("drain4_empty_n", 32'(empty_n[0]), 0);
        chk("drain4_ae_n", 32'(ae_n[0]), 0); chk("drain4_count", 32'(count[0]), 0);

        // Full ENQ+DEQ: legal when unguarded, overflow when guarded.
        step(1, 0, 8'h11, 0); step(1, 0, 8'h22, 0); step(1, 0, 8'h33, 0); step(1, 0, 8'h44, 0);
        step(1, 1, 8'h55, 0);
        chk("fulled_g0_dout", 32'(dout[0]), 32'h22); chk("fulled_g0_count", 32'(count[0]), 4);
        chk("fulled_g0_ovf", 32'(ovf[0]), 0);
        chk("fulled_g1_dout", 32'(dout[1]), 32'h22); chk("fulled_g1_count", 32'(count[1]), 3);
        chk("fulled_g1_ovf", 32'(ovf[1]), 1);
        step(1, 0, 8'h66, 0);
        chk("fullenq_g0_ovf", 32'(ovf[0]), 1); chk("fullenq_g1_count", 32'(count[1]), 4);
        step(0, 0, 8'h00, 1);
        chk("clr_g0_ovf", 32'(ovf[0]), 0); chk("clr_g1_ovf", 32'(ovf[1]), 0);

        // Underflow, then cleared.
        step(0, 1, 8'h00, 0); chk("unf_set", 32'(unf[0]), 1); chk("unf_count", 32'(count[0]), 0);
        step(0, 0, 8'h00, 1); chk("unf_clr", 32'(unf[0]), 0);

        // Streaming at two elements wraps both pointers many times.
        step(1, 0, 8'h01, 0); step(1, 0, 8'h02, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h30 + i), 0);
        chk("stream_dout", 32'(dout[0]), 32'h42); chk("stream_count", 32'(count[0]), 2);

        // Asynchronous reset mid-burst at three elements.
        step(1, 0, 8'h99, 0); chk("pre_rst_count", 32'(count[0]), 3);
        enq = 1'b1; din = 8'hEE; rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'hA5, 0);
        chk("post_rst_dout", 32'(dout[0]), 32'hA5); chk("post_rst_count", 32'(count[0]), 1);

        // CLR beats a simultaneous ENQ.
        step(1, 0, 8'h77, 1);
        chk("clr_enq_count", 32'(count[0]), 0); chk("clr_enq_empty_n", 32'(empty_n[0]), 0);
        step(1, 0, 8'h88, 0);
        chk("after_clr_dout", 32'(dout[0]), 32'h88); chk("after_clr_count", 32'(count[0]), 1);
        step(0, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
